mem_store_buffer: RTL

//  Write-direction counterpart of the WB load-extract path. Accepts store ops (SB/SH/SW) from MEM, aligns data and

---
 rtl/mem_store_buffer_pkg.sv | 14 +
 rtl/mem_store_buffer_align.sv | 38 +++
 rtl/mem_store_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: store function codes and the queued entry layout.
package mem_store_buffer_pkg;

    localparam logic [3:0] FUNC_SB = 4'b1001;
    localparam logic [3:0] FUNC_SH = 4'b1010;
    localparam logic [3:0] FUNC_SW = 4'b1011;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } st_entry_t;

endpackage

// File: rtl/mem_store_buffer_align.sv
// Store alignment: turns func/offset/data into byte enables, lane-replicated data and a misalign flag.
module store_align
    import mem_store_buffer_pkg::*;
(
    input  logic [3:0]  func,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        func_ok
);

    always_comb begin
        wen      = 4'b0000;
        wdata    = 32'h0;
        misalign = 1'b0;
        func_ok  = 1'b1;
        case (func)
            FUNC_SB: begin
                wen   = 4'b0001 << off;
                wdata = {4{data[7:0]}};
            end
            FUNC_SH: begin
                wen      = off[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{data[15:0]}};
                misalign = off[0];
            end
            FUNC_SW: begin
                wen      = 4'b1111;
                wdata    = data;
                misalign = (off != 2'b00);
            end
            default: func_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer between MEM and the data SRAM: aligns stores, queues them in a FIFO and drains one write at a time.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [3:0]  st_func,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_addr_err,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        ram_req,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    st_entry_t        fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0] count, count_next;
    logic [3:0]       al_wen;
    logic [31:0]      al_wdata;
    logic             al_misalign, al_func_ok;
    logic             enq, deq, hit;
    st_entry_t        new_entry, head;

    store_align u_align (
        .func     (st_func),
        .off      (st_addr[1:0]),
        .data     (st_data),
        .wen      (al_wen),
        .wdata    (al_wdata),
        .misalign (al_misalign),
        .func_ok  (al_func_ok)
    );

    assign st_addr_err = st_valid & al_misalign;
    assign enq         = st_valid & st_ready & al_func_ok & ~al_misalign;
    assign new_entry   = '{waddr: st_addr[31:2], wen: al_wen, wdata: al_wdata};
    // An empty FIFO forwards the incoming store straight to the SRAM port to get one-cycle latency.
    assign head        = (count == '0) ? new_entry : fifo[rd_ptr];
    assign empty       = (count == '0) && (state == IDLE);

    always_comb begin
        deq = 1'b0;
        case (state)
            IDLE: deq = (count != '0) || enq;
            BUSY: deq = ram_ack && (count != '0);
            default: deq = 1'b0;
        endcase
        count_next = count + CNT_W'(enq) - CNT_W'(deq);
    end

    always_comb begin
        hit = (state == BUSY) && (ram_addr[31:2] == ld_addr[31:2]);
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fifo[idx].waddr == ld_addr[31:2]))
                hit = 1'b1;
        end
        ld_hazard = ld_check & hit;
    end

    always_ff @(posedge clk) begin
        if (enq)
            fifo[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            st_ready  <= 1'b1;
            ram_req   <= 1'b0;
            ram_wen   <= 4'b0000;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            st_ready <= (count_next < CNT_W'(DEPTH));
            case (state)
                IDLE: begin
                    if (deq) begin
                        ram_req   <= 1'b1;
                        ram_wen   <= head.wen;
                        ram_addr  <= {head.waddr, 2'b00};
                        ram_wdata <= head.wdata;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (ram_ack) begin
                        if (deq) begin
                            ram_wen   <= head.wen;
                            ram_addr  <= {head.waddr, 2'b00};
                            ram_wdata <= head.wdata;
                        end else begin
                            ram_req <= 1'b0;
                            ram_wen <= 4'b0000;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
